// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared constants and types for the architectural register file:
//   register geometry, the write lane-select encodings and the flag bundle.
//   No ports; imported by the register file, its write-merge helper and
//   the bus interface.
package register_file_pkg;

    // Register geometry. The index width is fixed at 4 bits, so 16 registers.
    localparam int REG_COUNT   = 16;
    localparam int INDEX_WIDTH = 4;
    localparam int DATA_WIDTH  = 32;

    // Write lane-select encodings (write_width).
    localparam logic [1:0] WIDTH_BYTE     = 2'b00;
    localparam logic [1:0] WIDTH_WORD     = 2'b01;
    localparam logic [1:0] WIDTH_LONG     = 2'b10;
    localparam logic [1:0] WIDTH_RESERVED = 2'b11;

    // Latched ALU status flags.
    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic over;
    } flags_t;

endpackage

// File: rtl/register_file_if.sv
// register_file_if
//   Groups the read, writeback and flag signals between the core/ALU side
//   (master) and the register file (slave). The clock and reset are plain
//   ports on the register file, not part of this bundle.
//   Read:  read_enable, read_reg1/2/3_index -> reg1/2/3_data (1-clock latency)
//   Write: write_enable, write_index, write_width, write_data
//   Flags: flags_write, carry/zero/neg/over_in -> carry/zero/neg/over_out
//   There is no valid/ready handshake: every input is sampled on each rising
//   clock edge, and outputs are registered and hold while read_enable is low.
interface register_file_if;
    import register_file_pkg::*;

    logic                   read_enable;
    logic [INDEX_WIDTH-1:0] read_reg1_index;
    logic [INDEX_WIDTH-1:0] read_reg2_index;
    logic [INDEX_WIDTH-1:0] read_reg3_index;
    logic                   write_enable;
    logic [INDEX_WIDTH-1:0] write_index;
    logic [1:0]             write_width;
    logic [DATA_WIDTH-1:0]  write_data;
    logic                   flags_write;
    logic                   carry_in;
    logic                   zero_in;
    logic                   neg_in;
    logic                   over_in;
    logic [DATA_WIDTH-1:0]  reg1_data;
    logic [DATA_WIDTH-1:0]  reg2_data;
    logic [DATA_WIDTH-1:0]  reg3_data;
    logic                   carry_out;
    logic                   zero_out;
    logic                   neg_out;
    logic                   over_out;

    modport master (
        output read_enable, read_reg1_index, read_reg2_index, read_reg3_index,
        output write_enable, write_index, write_width, write_data,
        output flags_write, carry_in, zero_in, neg_in, over_in,
        input  reg1_data, reg2_data, reg3_data,
        input  carry_out, zero_out, neg_out, over_out
    );

    modport slave (
        input  read_enable, read_reg1_index, read_reg2_index, read_reg3_index,
        input  write_enable, write_index, write_width, write_data,
        input  flags_write, carry_in, zero_in, neg_in, over_in,
        output reg1_data, reg2_data, reg3_data,
        output carry_out, zero_out, neg_out, over_out
    );

endinterface

// File: rtl/register_write_merge.sv
// register_write_merge
//   Combinational lane merge for register writeback.
//   Ports:
//     old_value   in  32  current contents of the destination register
//     write_data  in  32  right-aligned writeback value
//     write_width in  2   byte / word / long / reserved
//     merged      out 32  value the register holds after the write
//     valid       out 1   low for the reserved encoding (write suppressed)
module register_write_merge
    import register_file_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] old_value,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [1:0]            write_width,
    output logic [DATA_WIDTH-1:0] merged,
    output logic                  valid
);

    always_comb begin
        merged = old_value;
        valid  = 1'b0;
        case (write_width)
            WIDTH_BYTE: begin
                merged = {old_value[31:8], write_data[7:0]};
                valid  = 1'b1;
            end
            WIDTH_WORD: begin
                merged = {old_value[31:16], write_data[15:0]};
                valid  = 1'b1;
            end
            WIDTH_LONG: begin
                merged = write_data;
                valid  = 1'b1;
            end
            default: begin
                merged = old_value;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/register_file.sv
// register_file
//   Architectural register file (16 x 32) plus ALU status flags.
//   Ports:
//     clock  in  system clock, all state on the rising edge
//     reset  in  synchronous active-high reset: clears registers, read
//                outputs and flags; writes in that cycle are ignored
//     bus    register_file_if.slave (read ports, writeback, flags)
//   Reads are registered (1-clock latency) and hold while read_enable is low.
//   A same-cycle write to a register being read is forwarded to that read
//   port (write-through bypass). Flags have no bypass.
//   Build option: define REGISTERS_R0_ZERO_EN to hard-wire register 0 to zero
//   (writes to index 0 discarded, reads of index 0 return 0).
module register_file
    import register_file_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    register_file_if.slave bus
);

    logic [DATA_WIDTH-1:0]  regs [REG_COUNT];
    logic [DATA_WIDTH-1:0]  merged_value;
    logic                   merge_valid;
    logic                   commit;
    logic [INDEX_WIDTH-1:0] read_index [3];
    logic [DATA_WIDTH-1:0]  read_next  [3];
    logic [DATA_WIDTH-1:0]  read_q     [3];
    flags_t                 flags_q;

    // One merge unit feeds both the storage update and all three bypasses.
    register_write_merge u_merge (
        .old_value   (regs[bus.write_index]),
        .write_data  (bus.write_data),
        .write_width (bus.write_width),
        .merged      (merged_value),
        .valid       (merge_valid)
    );

    always_comb begin
        commit = bus.write_enable && merge_valid;
`ifdef REGISTERS_R0_ZERO_EN
        if (bus.write_index == '0) begin
            commit = 1'b0;
        end
`endif
    end

    assign read_index[0] = bus.read_reg1_index;
    assign read_index[1] = bus.read_reg2_index;
    assign read_index[2] = bus.read_reg3_index;

    // Each read port forwards the merged value independently when it hits
    // the register being committed this edge.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            read_next[p] = regs[read_index[p]];
            if (commit && (read_index[p] == bus.write_index)) begin
                read_next[p] = merged_value;
            end
`ifdef REGISTERS_R0_ZERO_EN
            if (read_index[p] == '0) begin
                read_next[p] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            for (int p = 0; p < 3; p++) begin
                read_q[p] <= '0;
            end
            flags_q <= '0;
        end else begin
            if (commit) begin
                regs[bus.write_index] <= merged_value;
            end
            if (bus.read_enable) begin
                for (int p = 0; p < 3; p++) begin
                    read_q[p] <= read_next[p];
                end
            end
            if (bus.flags_write) begin
                flags_q <= '{carry: bus.carry_in, zero: bus.zero_in,
                             neg: bus.neg_in, over: bus.over_in};
            end
        end
    end

    assign bus.reg1_data = read_q[0];
    assign bus.reg2_data = read_q[1];
    assign bus.reg3_data = read_q[2];
    assign bus.carry_out = flags_q.carry;
    assign bus.zero_out  = flags_q.zero;
    assign bus.neg_out   = flags_q.neg;
    assign bus.over_out  = flags_q.over;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Self-checking bench for register_file: directed scenarios followed by
//   randomized traffic, compared against a behavioural model through an
//   expected-value queue popped by an independent monitor.
module tb_register_file;
    import register_file_pkg::*;

    // Expected snapshot: {reg1, reg2, reg3, carry, zero, neg, over}
    localparam int EXP_W = 3 * 32 + 4;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    register_file_if bus ();

    register_file dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_regs [16];
    logic [31:0] m_out  [3];
    logic [3:0]  m_flags;

    logic [EXP_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    // Applies one clock of stimulus to the model: storage is updated first,
    // then enabled reads see the post-write contents, which is exactly what
    // write-through bypass promises.
    task automatic model_step(input logic rst, input logic re,
                              input logic [3:0] i1, input logic [3:0] i2,
                              input logic [3:0] i3, input logic we,
                              input logic [3:0] wi, input logic [1:0] ww,
                              input logic [31:0] wd, input logic fw,
                              input logic [3:0] fl);
        logic [31:0] old;
        logic        discard;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
            for (int p = 0; p < 3; p++) m_out[p] = 32'h0;
            m_flags = 4'h0;
            return;
        end
        discard = 1'b0;
`ifdef REGISTERS_R0_ZERO_EN
        discard = (wi == 4'd0);
`endif
        if (we && !discard) begin
            old = m_regs[wi];
            if (ww == 2'b00)      m_regs[wi] = (old & 32'hFFFF_FF00) | (wd & 32'h0000_00FF);
            else if (ww == 2'b01) m_regs[wi] = (old & 32'hFFFF_0000) | (wd & 32'h0000_FFFF);
            else if (ww == 2'b10) m_regs[wi] = wd;
        end
        if (re) begin
            m_out[0] = m_regs[i1];
            m_out[1] = m_regs[i2];
            m_out[2] = m_regs[i3];
        end
        if (fw) m_flags = fl;
    endtask

    // ---------------- driver ----------------
    // Drives one cycle; fl is {carry, zero, neg, over}.
    task automatic drive(input logic rst, input logic re,
                         input logic [3:0] i1, input logic [3:0] i2,
                         input logic [3:0] i3, input logic we,
                         input logic [3:0] wi, input logic [1:0] ww,
                         input logic [31:0] wd, input logic fw,
                         input logic [3:0] fl);
        reset               = rst;
        bus.read_enable     = re;
        bus.read_reg1_index = i1;
        bus.read_reg2_index = i2;
        bus.read_reg3_index = i3;
        bus.write_enable    = we;
        bus.write_index     = wi;
        bus.write_width     = ww;
        bus.write_data      = wd;
        bus.flags_write     = fw;
        bus.carry_in        = fl[3];
        bus.zero_in         = fl[2];
        bus.neg_in          = fl[1];
        bus.over_in         = fl[0];
        model_step(rst, re, i1, i2, i3, we, wi, ww, wd, fw, fl);
        @(posedge clock);
        exp_q.push_back({m_out[0], m_out[1], m_out[2], m_flags});
        #1;
    endtask

    task automatic read3(input logic [3:0] i1, input logic [3:0] i2, input logic [3:0] i3);
        drive(1'b0, 1'b1, i1, i2, i3, 1'b0, 4'd0, WIDTH_LONG, 32'h0, 1'b0, 4'h0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [EXP_W-1:0] e;
        logic [3:0]       act_flags;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act_flags = {bus.carry_out, bus.zero_out, bus.neg_out, bus.over_out};
            checks++;
            if (bus.reg1_data !== e[99:68]) begin
                errors++;
                $display("FAIL reg1_data @%0t: got %08h expected %08h", $time, bus.reg1_data, e[99:68]);
            end
            checks++;
            if (bus.reg2_data !== e[67:36]) begin
                errors++;
                $display("FAIL reg2_data @%0t: got %08h expected %08h", $time, bus.reg2_data, e[67:36]);
            end
            checks++;
            if (bus.reg3_data !== e[35:4]) begin
                errors++;
                $display("FAIL reg3_data @%0t: got %08h expected %08h", $time, bus.reg3_data, e[35:4]);
            end
            checks++;
            if (act_flags !== e[3:0]) begin
                errors++;
                $display("FAIL flags @%0t: got %b expected %b", $time, act_flags, e[3:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        for (int p = 0; p < 3; p++) m_out[p] = 32'h0;
        m_flags = 4'h0;
        reset = 1'b1;
        bus.read_enable = 1'b0;
        bus.read_reg1_index = '0;
        bus.read_reg2_index = '0;
        bus.read_reg3_index = '0;
        bus.write_enable = 1'b0;
        bus.write_index = '0;
        bus.write_width = '0;
        bus.write_data = '0;
        bus.flags_write = 1'b0;
        bus.carry_in = 1'b0;
        bus.zero_in = 1'b0;
        bus.neg_in = 1'b0;
        bus.over_in = 1'b0;
        @(posedge clock);
        #1;

        // Reset with a write and flag update pending: both ignored.
        drive(1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 4'd3, WIDTH_LONG, 32'hDEAD_BEEF, 1'b1, 4'hF);
        read3(4'd3, 4'd3, 4'd3);

        // Long write then read on the reg2 port.
        drive(1'b0, 1'b1, 4'd1, 4'd2, 4'd4, 1'b1, 4'd5, WIDTH_LONG, 32'h1234_5678, 1'b0, 4'h0);
        read3(4'd1, 4'd5, 4'd1);

        // Byte, word and reserved-width writes to r5.
        drive(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 4'd5, WIDTH_BYTE, 32'hFFFF_FFAA, 1'b0, 4'h0);
        read3(4'd5, 4'd5, 4'd5);
        drive(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 4'd5, WIDTH_WORD, 32'hFFFF_BBCC, 1'b0, 4'h0);
        read3(4'd5, 4'd5, 4'd5);
        drive(1'b0, 1'b1, 4'd5, 4'd5, 4'd5, 1'b1, 4'd5, WIDTH_RESERVED, 32'hFFFF_FFFF, 1'b0, 4'h0);
        read3(4'd5, 4'd5, 4'd5);

        // Same-cycle bypass on two ports at once.
        drive(1'b0, 1'b1, 4'd5, 4'd7, 4'd7, 1'b1, 4'd7, WIDTH_LONG, 32'hCAFE_F00D, 1'b0, 4'h0);
        // Byte-merge bypass on all three ports.
        drive(1'b0, 1'b1, 4'd7, 4'd7, 4'd7, 1'b1, 4'd7, WIDTH_BYTE, 32'h0000_0011, 1'b0, 4'h0);

        // Stall: read_enable low while r2 is rewritten.
        drive(1'b0, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 4'd2, WIDTH_LONG, 32'h1111_1111, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 4'd2, 4'd2, 4'd2, 1'b1, 4'd2, WIDTH_LONG, 32'h2222_2222, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 4'd2, 4'd2, 4'd2, 1'b1, 4'd2, WIDTH_WORD, 32'h0000_3333, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 4'd2, 4'd2, 4'd2, 1'b0, 4'd2, WIDTH_LONG, 32'h0, 1'b0, 4'h0);
        read3(4'd2, 4'd2, 4'd2);

        // Flags latch only on flags_write, independent of reads/writes.
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, WIDTH_LONG, 32'h0, 1'b1, 4'b1011);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, WIDTH_LONG, 32'h0, 1'b0, 4'b0100);
        drive(1'b0, 1'b1, 4'd1, 4'd1, 4'd1, 1'b1, 4'd1, WIDTH_LONG, 32'h5555_AAAA, 1'b1, 4'b0110);

        // Register 0 write with same-cycle read, then later reads.
        drive(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, WIDTH_LONG, 32'hFFFF_FFFF, 1'b0, 4'h0);
        read3(4'd0, 4'd0, 4'd0);
        read3(4'd0, 4'd1, 4'd0);

        // Reset during a stall clears the held outputs.
        drive(1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 1'b0, 4'd0, WIDTH_LONG, 32'h0, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 4'd1, 4'd1, 4'd1, 1'b1, 4'd1, WIDTH_LONG, 32'h9999_9999, 1'b0, 4'h0);
        read3(4'd1, 4'd5, 4'd7);

        // Randomized traffic; read indices often alias the write index.
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  wi;
            logic [3:0]  ri [3];
            wi = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++) begin
                ri[p] = ($urandom_range(0, 2) == 0) ? wi : 4'($urandom_range(0, 15));
            end
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) != 0),
                  ri[0], ri[1], ri[2],
                  ($urandom_range(0, 2) != 0),
                  wi,
                  2'($urandom_range(0, 3)),
                  $urandom,
                  ($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 15)));
        end

        // Let the monitor consume the final snapshot.
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file and status-flag store directly upstream of the ALU.
- Supplies the reg2/reg3 operands (plus reg1 store data) one clock after indices are presented.
- Accepts result writeback with byte/word/long lane control.
- Holds the carry/zero/neg/over flags; the latched carry feeds back as the ALU carry_in.

Parameters:
- REG_COUNT, 16, number of 32-bit general registers; index width is fixed at 4 bits.
- DATA_WIDTH, 32, register width; only 32 is supported.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- read_enable  in  1  when high, read outputs update this edge; when low, they hold (stall)
- read_reg1_index  in  4  index for reg1_data (store data)
- read_reg2_index  in  4  index for reg2_data (ALU operand A)
- read_reg3_index  in  4  index for reg3_data (ALU operand B)
- write_enable  in  1  commit write_data to write_index this edge
- write_index  in  4  destination register
- write_width  in  2  lane select: byte, word, long, reserved
- write_data  in  32  writeback value, right-aligned
- flags_write  in  1  latch the four flag inputs this edge
- carry_in, zero_in, neg_in, over_in  in  1 each  flags from the ALU
- reg1_data, reg2_data, reg3_data  out  32 each  registered read data
- carry_out, zero_out, neg_out, over_out  out  1 each  latched flags; carry_out drives the ALU carry_in

Behaviour:
- Reset (sync, active-high):
  - All registers, all read outputs and all flags go to 0 on the edge where reset is sampled high.
  - Writes and flags_write in that cycle are ignored.
  - Reset mid-stall also clears the outputs.
- Read latency is 1 clock. Outputs register the selected value when read_enable=1, otherwise hold their previous value.
- Write lane merge (byte=00, word=01, long=10):
  - byte: new[7:0]=write_data[7:0], upper 24 bits preserved.
  - word: new[15:0]=write_data[15:0], upper 16 bits preserved.
  - long: all 32 bits replaced.
  - 11 (reserved): no write, and no bypass.
- Write-through bypass:
  - Applies when write_enable=1, read_enable=1 and a read index equals write_index in the same cycle.
  - That read output takes the merged new value, not the stale one.
  - Any combination of the three read ports may hit simultaneously; each bypasses independently.
- Flags:
  - When flags_write=1, all four flags latch at the edge and are visible the next cycle.
  - There is no flag bypass: the ALU sees the old carry during the same cycle.
  - Flags are independent of read_enable and write_enable.
- Simultaneous write and flags_write in one cycle are both honoured.
- A write with read_enable=0 updates storage. The held outputs do not change, even for a matching index.
- There is no state machine beyond storage and output registers. No combinational path from inputs to outputs.

Optional Feature:
- Macro: REGISTERS_R0_ZERO_EN.
- Defined:
  - Register 0 always reads 0, including through bypass.
  - Writes to index 0 are discarded.
- Undefined: register 0 is an ordinary register.

Decomposition:
- The lane-select encodings go in the shared registers.vh: WIDTH_BYTE=2'b00, WIDTH_WORD=2'b01, WIDTH_LONG=2'b10, WIDTH_RESERVED=2'b11.
- Also in registers.vh: REG_COUNT and the index width of 4.
- One combinational sub-module, register_write_merge (old value, write_data, write_width -> merged value, valid).
  - Instanced once.
  - Its output is shared by the storage update and all three bypass paths.

Test Plan:
- Reset with write_enable=1, index 3, data 0xDEADBEEF -> r3 reads 0 after reset is released; all outputs and flags are 0.
- Long write of 0x12345678 to r5, then read on r2 port next cycle -> reg2_data=0x12345678 one clock after the index is presented.
- r5=0x12345678, byte write 0xAA, then word write 0xBBCC -> reads 0x123456AA, then 0x1234BBCC; width 11 leaves the value unchanged.
- Same-cycle long write 0xCAFEF00D to r7 with read_reg2_index=read_reg3_index=7 -> both outputs show 0xCAFEF00D next cycle.
- read_enable=0 for 3 cycles while r2 is rewritten -> reg2_data holds the old value; it shows the new value on the first cycle after read_enable returns.
- flags_write with carry_in=1, zero_in=0, neg_in=1, over_in=1 -> the outputs show 1,0,1,1 the next cycle. They are unchanged when flags_write=0.
- With REGISTERS_R0_ZERO_EN, write 0xFFFFFFFF to r0 with a same-cycle read of r0 -> reads 0 then and on every later cycle.
